// File: rtl/ie_muldiv_seq.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide,
// with MTHI/MTLO/MFHI/MFLO access, pipeline stall, flush and divide-by-zero reporting.
module ie_muldiv_seq #(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [NB_FUNCT-1:0] i_funct,
    input  logic [NB_DATA-1:0]  i_data_1,
    input  logic [NB_DATA-1:0]  i_data_2,
    input  logic                i_flush,
    output logic                o_stall,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_div_zero,
    output logic [NB_DATA-1:0]  o_hi,
    output logic [NB_DATA-1:0]  o_lo,
    output logic [NB_DATA-1:0]  o_result
);

    localparam int NB_CNT = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);

    localparam logic [NB_FUNCT-1:0] FN_MFHI  = NB_FUNCT'('h10);
    localparam logic [NB_FUNCT-1:0] FN_MTHI  = NB_FUNCT'('h11);
    localparam logic [NB_FUNCT-1:0] FN_MFLO  = NB_FUNCT'('h12);
    localparam logic [NB_FUNCT-1:0] FN_MTLO  = NB_FUNCT'('h13);
    localparam logic [NB_FUNCT-1:0] FN_MULT  = NB_FUNCT'('h18);
    localparam logic [NB_FUNCT-1:0] FN_MULTU = NB_FUNCT'('h19);
    localparam logic [NB_FUNCT-1:0] FN_DIV   = NB_FUNCT'('h1A);
    localparam logic [NB_FUNCT-1:0] FN_DIVU  = NB_FUNCT'('h1B);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t                 state_q, state_d;
    logic [NB_CNT-1:0]      cnt_q, cnt_d;
    logic [2*NB_DATA-1:0]   prod_q, prod_d;
    logic [NB_DATA-1:0]     opnd_q, opnd_d;
    logic                   is_div_q, is_div_d;
    logic                   sign_a_q, sign_a_d;
    logic                   sign_b_q, sign_b_d;
    logic [NB_DATA-1:0]     hi_q, hi_d;
    logic [NB_DATA-1:0]     lo_q, lo_d;
    logic                   done_q, done_d;
    logic                   div_zero_q, div_zero_d;

    logic                   is_mul, is_div, is_signed_op, is_known, busy, accept;
    logic [NB_DATA-1:0]     mag_a, mag_b, quo_fix, rem_fix;
    logic [NB_DATA:0]       mul_sum, div_shift, div_diff;
    logic [2*NB_DATA-1:0]   prod_fix;

    always_comb begin
        is_mul       = (i_funct == FN_MULT) || (i_funct == FN_MULTU);
        is_div       = (i_funct == FN_DIV)  || (i_funct == FN_DIVU);
        is_signed_op = (i_funct == FN_MULT) || (i_funct == FN_DIV);
        is_known     = is_mul || is_div ||
                       (i_funct == FN_MFHI) || (i_funct == FN_MTHI) ||
                       (i_funct == FN_MFLO) || (i_funct == FN_MTLO);
        busy         = (state_q != IDLE);
        accept       = i_valid && !busy && !i_flush;
        mag_a        = (is_signed_op && i_data_1[NB_DATA-1]) ? -i_data_1 : i_data_1;
        mag_b        = (is_signed_op && i_data_2[NB_DATA-1]) ? -i_data_2 : i_data_2;

        // Multiply keeps the multiplier in the low half and shifts the running sum in from the top.
        mul_sum   = {1'b0, prod_q[2*NB_DATA-1:NB_DATA]} +
                    ({1'b0, opnd_q} & {(NB_DATA+1){prod_q[0]}});
        div_shift = {prod_q[2*NB_DATA-1:NB_DATA], prod_q[NB_DATA-1]};
        div_diff  = div_shift - {1'b0, opnd_q};

        prod_fix = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -prod_q[NB_DATA-1:0] : prod_q[NB_DATA-1:0];
        rem_fix  = sign_a_q ? -prod_q[2*NB_DATA-1:NB_DATA] : prod_q[2*NB_DATA-1:NB_DATA];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_div && (i_data_2 == '0)) begin
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end else if (is_mul || is_div) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        prod_d   = {{NB_DATA{1'b0}}, mag_a};
                        opnd_d   = mag_b;
                        is_div_d = is_div;
                        sign_a_d = is_signed_op && i_data_1[NB_DATA-1];
                        sign_b_d = is_signed_op && i_data_2[NB_DATA-1];
                    end else if (i_funct == FN_MTHI) begin
                        hi_d = i_data_1;
                    end else if (i_funct == FN_MTLO) begin
                        lo_d = i_data_1;
                    end
                end
            end
            RUN: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else begin
                    if (!is_div_q) begin
                        prod_d = {mul_sum, prod_q[NB_DATA-1:1]};
                    end else if (div_diff[NB_DATA]) begin
                        prod_d = {div_shift[NB_DATA-1:0], prod_q[NB_DATA-2:0], 1'b0};
                    end else begin
                        prod_d = {div_diff[NB_DATA-1:0], prod_q[NB_DATA-2:0], 1'b1};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!i_flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prod_q     <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        o_result = '0;
        if (!busy && (i_funct == FN_MFHI)) begin
            o_result = hi_q;
        end else if (!busy && (i_funct == FN_MFLO)) begin
            o_result = lo_q;
        end
    end

    assign o_stall    = i_valid && busy && is_known;
    assign o_busy     = busy;
    assign o_done     = done_q;
    assign o_div_zero = div_zero_q;
    assign o_hi       = hi_q;
    assign o_lo       = lo_q;

endmodule

// File: tb/tb_ie_muldiv_seq.sv
// Directed bench for ie_muldiv_seq: table of multiply/divide vectors plus hand-written
// sequences for divide-by-zero, stall, flush, reset and back-to-back corner cases.
module tb_ie_muldiv_seq;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_NOP   = 6'h00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [5:0]  funct;
    logic [31:0] data_1, data_2;
    logic        flush;
    logic        stall, busy, done, div_zero;
    logic [31:0] hi, lo, result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    ie_muldiv_seq #(.NB_DATA(32), .NB_FUNCT(6)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_funct    (funct),
        .i_data_1   (data_1),
        .i_data_2   (data_2),
        .i_flush    (flush),
        .o_stall    (stall),
        .o_busy     (busy),
        .o_done     (done),
        .o_div_zero (div_zero),
        .o_hi       (hi),
        .o_lo       (lo),
        .o_result   (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one instruction for exactly one rising edge (E0); returns just after that edge.
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid  = 1'b1;
        funct  = f;
        data_1 = a;
        data_2 = b;
        @(posedge clk);
        #1;
        valid = 1'b0;
        funct = FN_NOP;
    endtask

    task automatic waitDone(output int edges);
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        int edges;
        int stalls;
        int dones;

        vecs[0] = '{"mult neg x pos",   FN_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{"multu max x max",  FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{"div neg / pos",    FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{"div min / -1",     FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4] = '{"divu 100 / 7",     FN_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[5] = '{"mult pos x neg",   FN_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[6] = '{"div pos / neg",    FN_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{"divu max / 16",    FN_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[8] = '{"multu carry out",  FN_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[9] = '{"mult min x min",   FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        rst_n  = 1'b0;
        valid  = 1'b0;
        funct  = FN_MFLO;
        data_1 = '0;
        data_2 = '0;
        flush  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset hi", hi, 0);
        checkOutput("reset lo", lo, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset div_zero", div_zero, 0);
        checkOutput("reset result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(FN_MTHI, 32'h12345678, 0);
        applyStimulus(FN_MTLO, 32'h0BADF00D, 0);
        funct = FN_MFHI;
        #1;
        checkOutput("mfhi result", result, 32'h12345678);
        funct = FN_MFLO;
        #1;
        checkOutput("mflo result", result, 32'h0BADF00D);
        funct = FN_NOP;
        #1;
        checkOutput("other funct result", result, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].funct, vecs[i].a, vecs[i].b);
            checkOutput({vecs[i].name, " busy"}, busy, 1);
            waitDone(edges);
            checkOutput({vecs[i].name, " latency"}, edges, 33);
            checkOutput({vecs[i].name, " hi"}, hi, vecs[i].hi);
            checkOutput({vecs[i].name, " lo"}, lo, vecs[i].lo);
            checkOutput({vecs[i].name, " div_zero"}, div_zero, 0);
        end
        @(posedge clk);
        #1;
        checkOutput("done single cycle", done, 0);

        // Second operation accepted on the edge that ends the o_done cycle.
        applyStimulus(FN_DIV, 32'hFFFFFFF9, 32'h00000002);
        waitDone(edges);
        applyStimulus(FN_MULTU, 32'd2, 32'd3);
        checkOutput("back-to-back busy", busy, 1);
        waitDone(edges);
        checkOutput("back-to-back latency", edges, 33);
        checkOutput("back-to-back lo", lo, 6);
        checkOutput("back-to-back hi", hi, 0);

        applyStimulus(FN_MTHI, 32'hAAAA0001, 0);
        applyStimulus(FN_MTLO, 32'hBBBB0002, 0);
        applyStimulus(FN_DIVU, 32'd7, 32'd0);
        checkOutput("div0 done", done, 1);
        checkOutput("div0 flag", div_zero, 1);
        checkOutput("div0 busy", busy, 0);
        checkOutput("div0 hi kept", hi, 32'hAAAA0001);
        checkOutput("div0 lo kept", lo, 32'hBBBB0002);
        @(posedge clk);
        #1;
        checkOutput("div0 done pulse", done, 0);
        checkOutput("div0 flag pulse", div_zero, 0);

        applyStimulus(FN_MULTU, 32'h0000FFFF, 32'h0000FFFF);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush busy", busy, 0);
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checkOutput("flush no done", dones, 0);
        checkOutput("flush hi kept", hi, 32'hAAAA0001);
        checkOutput("flush lo kept", lo, 32'hBBBB0002);

        @(negedge clk);
        flush  = 1'b1;
        valid  = 1'b1;
        funct  = FN_MULT;
        data_1 = 32'd3;
        data_2 = 32'd3;
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid = 1'b0;
        funct = FN_NOP;
        checkOutput("flush beats valid busy", busy, 0);
        checkOutput("flush beats valid done", done, 0);

        applyStimulus(FN_MULTU, 32'd5, 32'd6);
        valid = 1'b1;
        funct = FN_MFLO;
        stalls = 0;
        edges = 0;
        #1;
        while (!done && edges < 40) begin
            if (stall) stalls++;
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("mflo stall cycles", stalls, 33);
        checkOutput("mflo stall released", stall, 0);
        checkOutput("mflo result after done", result, 32'h0000001E);
        valid = 1'b0;
        funct = FN_NOP;

        applyStimulus(FN_MTLO, 32'h00000055, 0);
        applyStimulus(FN_MULT, 32'd3, 32'd4);
        valid  = 1'b1;
        funct  = FN_MTLO;
        data_1 = 32'h0000CAFE;
        stalls = 0;
        edges = 0;
        #1;
        while (!done && edges < 40) begin
            if (stall) stalls++;
            if (edges == 16) checkOutput("mtlo busy lo kept", lo, 32'h00000055);
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("mtlo stall cycles", stalls, 33);
        checkOutput("mtlo lo at done", lo, 12);
        @(posedge clk);
        #1;
        valid = 1'b0;
        funct = FN_NOP;
        checkOutput("mtlo accepted lo", lo, 32'h0000CAFE);
        checkOutput("mtlo accepted hi", hi, 0);

        applyStimulus(FN_MULT, 32'd100, 32'd200);
        repeat (5) @(posedge clk);
        @(negedge clk);
        funct = FN_MFLO;
        rst_n = 1'b0;
        #1;
        checkOutput("midop reset busy", busy, 0);
        checkOutput("midop reset done", done, 0);
        checkOutput("midop reset div_zero", div_zero, 0);
        checkOutput("midop reset hi", hi, 0);
        checkOutput("midop reset lo", lo, 0);
        checkOutput("midop reset result", result, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        valid  = 1'b1;
        funct  = FN_MULTU;
        data_1 = 32'd9;
        data_2 = 32'd9;
        @(posedge clk);
        #1;
        valid = 1'b0;
        funct = FN_NOP;
        checkOutput("first edge accept busy", busy, 1);
        waitDone(edges);
        checkOutput("first edge accept latency", edges, 33);
        checkOutput("first edge accept lo", lo, 81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ie_muldiv_seq.md
IE_MULDIV_SEQ -- requirements
Module: ie_muldiv_seq

Interface
REQ-001 Parameter NB_DATA, default 32, SHALL set operand, HI, LO and result width.
REQ-002 Parameter NB_FUNCT, default 6, SHALL set the function-code width.
REQ-003 Clocking SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 i_clk  in  1  rising-edge clock.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_valid  in  1  instruction present this cycle.
REQ-007 i_funct  in  NB_FUNCT  function code: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
REQ-008 i_data_1  in  NB_DATA  rs operand (multiplicand, dividend, MTHI/MTLO source).
REQ-009 i_data_2  in  NB_DATA  rt operand (multiplier, divisor).
REQ-010 i_flush  in  1  abort the operation in progress.
REQ-011 o_stall  out  1  combinational; pipeline SHALL hold the instruction.
REQ-012 o_busy  out  1  iterative operation in progress.
REQ-013 o_done  out  1  one-cycle completion pulse.
REQ-014 o_div_zero  out  1  divisor-zero flag, pulses with o_done.
REQ-015 o_hi, o_lo  out  NB_DATA each  architectural HI/LO registers.
REQ-016 o_result  out  NB_DATA  HI for MFHI, LO for MFLO, zero otherwise.

Function
REQ-017 FSM states SHALL be IDLE, RUN and FIX; o_busy SHALL be 1 in RUN and FIX.
REQ-018 A MULT/MULTU/DIV/DIVU SHALL be accepted on an edge where i_valid=1, o_busy=0 and i_flush=0; this is edge E0.
REQ-019 At E0, signed ops SHALL latch operand magnitudes plus both sign bits; unsigned ops SHALL latch operands as-is; the state SHALL become RUN with a 5-bit counter of 0.
REQ-020 RUN SHALL process one bit per edge: shift-add for multiply, restoring shift-subtract for divide; after 32 iterations (edge E32) the state SHALL become FIX.
REQ-021 Signed multiply in FIX: the 64-bit product SHALL be negated when the operand signs differ; {HI,LO} = product.
REQ-022 Signed divide in FIX: the quotient SHALL be negated when the operand signs differ; the remainder SHALL take the dividend sign; LO = quotient, HI = remainder.
REQ-023 Division of 0x80000000 by 0xFFFFFFFF (signed) SHALL give LO=0x80000000, HI=0, with no special case.
REQ-024 At E33 HI/LO SHALL update, the state SHALL become IDLE, and o_done SHALL be 1 for exactly the following cycle.
REQ-025 DIV/DIVU with i_data_2=0 SHALL skip RUN; at E0 the state SHALL stay IDLE, HI/LO SHALL be unchanged, and o_done and o_div_zero SHALL be 1 for the next cycle.
REQ-026 MTHI/MTLO with i_valid=1 and o_busy=0 SHALL write i_data_1 to HI/LO on that edge.
REQ-027 MFHI/MFLO with o_busy=0 SHALL drive o_result combinationally from the current HI/LO.
REQ-028 o_stall SHALL equal i_valid AND o_busy AND i_funct being any of the eight codes in REQ-007; other codes SHALL never stall.
REQ-029 A request presented while o_busy=1 SHALL be ignored; the pipeline holds it via o_stall.
REQ-030 i_flush=1 in RUN or FIX SHALL force IDLE on the next edge; no o_done pulse, HI/LO unchanged.
REQ-031 If i_flush and i_valid are both 1, flush SHALL win and the request SHALL NOT be accepted.
REQ-032 A new operation SHALL be acceptable in the cycle o_done is high.

Reset
REQ-033 i_rst_n=0 SHALL immediately force IDLE, counter=0, HI=LO=0, o_busy=o_done=o_div_zero=0, including mid-operation.
REQ-034 After reset release, the first edge SHALL be able to accept a request.

Verification
REQ-035 MULT 0xFFFFFFFE x 0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; o_done exactly 33 edges after E0.
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> o_div_zero=1 and o_done=1 one cycle after E0, HI/LO unchanged.
REQ-038 MFLO held with i_valid=1 during MULTU 5x6 -> o_stall=1 until the o_done cycle, then o_result=0x0000001E.
REQ-039 i_flush at iteration 10 -> o_busy=0 next cycle, no o_done, prior HI/LO retained; repeat with i_rst_n=0 mid-operation -> all outputs 0.
REQ-040 MTHI 0x12345678 then MFHI -> o_result=0x12345678; MTLO while busy -> stalled, LO unchanged until accepted.
